mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-read-port/single-write-port testbench/FPGA RAM (registered read, 3-clock read-data latency, write committed on the clock edge) between NREQ requesters, e.g. CPU, video scanner and loader. Grants one access per clock by round-robin, drives the RAM address, write-data and write-enable lines from registers, and returns read data to the correct requester. A tag pipeline matched to the RAM latency routes each read result.

## Interface
- NREQ, 2: number of requesters (2..8).
- BITS_ADDR, 14: RAM address width.
- BITS_DATA, 8: RAM data width.
- MEM_LAT, 3: clocks from RAM address sample to valid q.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request; held high until granted.
- we  in  NREQ  per-requester write flag (1 = write, 0 = read).
- addr  in  NREQ*BITS_ADDR  packed addresses; requester i at [i*BITS_ADDR +: BITS_ADDR].
- wdata  in  NREQ*BITS_DATA  packed write data, same packing.
- gnt  out  NREQ  one-hot accept strobe, combinational, at most one bit set.
- rvalid  out  NREQ  one-hot read-data-valid strobe.
- rdata  out  BITS_DATA  read data, shared by all requesters, qualified by rvalid.
- mem_addr_rd  out  BITS_ADDR  RAM read address, registered.
- mem_q  in  BITS_DATA  RAM read data.
- mem_addr_wr  out  BITS_ADDR  RAM write address, registered.
- mem_data_wr  out  BITS_DATA  RAM write data, registered.
- mem_wren  out  1  RAM write enable, registered.

## Operation
- Arbitration:
  - ptr (log2 NREQ bits) holds the highest-priority index.
  - Search order is ptr, ptr+1, … modulo NREQ. The first requester with req=1 gets gnt.
  - On any grant, ptr <= winner+1 modulo NREQ. With no request, ptr holds.
- Granted read:
  - mem_addr_rd <= addr[winner].
  - Tag {valid=1, id=winner} enters the tag shift register, depth MEM_LAT+1.
- Granted write:
  - mem_addr_wr <= addr[winner], mem_data_wr <= wdata[winner], mem_wren <= 1.
  - The tag entered is valid=0.
- No grant: mem_wren <= 0. A valid=0 tag enters. mem_addr_rd holds its last value.
- Read return:
  - rvalid[id] = 1 when the tail tag has valid=1.
  - rdata = mem_q, passed through combinationally.
  - Requesters must accept rvalid unconditionally; there is no backpressure.
- Ordering: accesses commit in grant order. A read granted on any cycle after a write to the same address returns the new data; the RAM writes before the next read sample. No forwarding logic exists.
- Reset (rst_n=0 at a clock edge):
  - ptr=0, all tags invalid, mem_wren=0, mem_addr_rd=0, mem_addr_wr=0, mem_data_wr=0.
  - gnt is forced to 0 while rst_n=0.
  - In-flight reads are dropped: no rvalid for any read granted before reset, even though mem_q still changes.

## Timing
- Grant cycle N: req[i]=1 and gnt[i]=1 in the same cycle. The requester may change addr/we/wdata or drop req from N+1.
- Read path:
  - mem_addr_rd is valid in N+1; the RAM samples it at the end of N+1.
  - mem_q and rvalid[i] are valid in cycle N+1+MEM_LAT (N+4 at default).
  - Total read latency is MEM_LAT+1 clocks from grant.
- Write path: mem_wren=1 in N+1 only; the RAM array updates at the end of N+1.
- Throughput: one access per clock sustained. Back-to-back reads from alternating requesters return in grant order, one per clock.
- Fairness: a continuously requesting requester waits at most NREQ-1 cycles for gnt.
- Simultaneous events: one grant only; the others keep req high. Reset has priority over a grant in the same cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - default BITS_ADDR, BITS_DATA, MEM_LAT;
  - the tag struct {valid, id};
  - function clog2 for the id width.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: req vector and ptr. Outputs: one-hot gnt and binary winner index.
- The tag shift register, output registers and ptr update stay in mem_arbiter.

## Test plan
- Single read: RAM preloaded [0x0010]=0xA5; req[0] read 0x0010 at cycle N -> gnt[0] at N, mem_addr_rd=0x0010 at N+1, rvalid[0]=1 and rdata=0xA5 at N+4 only.
- Write then read: req[1] writes 0x3FFF←0x5A at N, reads 0x3FFF at N+1 -> mem_wren=1 at N+1 only, rvalid[1] with 0x5A at N+5.
- Contention: req[0] and req[1] both held from reset release -> gnt alternates 0,1,0,1 starting with requester 0; read returns arrive in the same alternating order, one per clock.
- Fairness, NREQ=4: req=4'b1111 held -> each requester granted exactly once every 4 cycles, grant order 0,1,2,3.
- Reset mid-flight: reads granted at N and N+1, rst_n=0 at N+2 -> no rvalid in N+2..N+6, gnt=0 and mem_wren=0 during reset, ptr=0 afterwards.
- Idle: req=0 for 10 cycles -> gnt=0, rvalid=0, mem_wren=0, ptr unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - default RAM geometry and latency
//   - clog2 helper used to size requester indices
//   - tag_t: one entry of the read-return tag pipeline
package mem_arb_pkg;

  localparam int DEF_BITS_ADDR = 14;
  localparam int DEF_BITS_DATA = 8;
  localparam int DEF_MEM_LAT   = 3;
  localparam int MAX_NREQ      = 8;

  // Ceiling log2, never below 1 so a 2-requester index is still one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Tag id is sized for the largest supported arbiter; smaller arbiters
  // zero-extend their requester index into it.
  localparam int ID_W = clog2(MAX_NREQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter.
//   req/we/addr/wdata : driven by the requesters (packed, requester i at slot i)
//   gnt               : one-hot accept strobe from the arbiter
//   rvalid/rdata      : one-hot read return strobe and shared read data
//
// Handshake: a requester raises req[i] with we/addr/wdata stable and keeps it
// high until it sees gnt[i]=1 in the same cycle; that cycle is the transfer and
// the requester may change or drop its signals from the next cycle. Read data
// comes back later as a single-cycle rvalid[i] pulse with rdata valid in that
// cycle only; there is no backpressure, so rvalid must be consumed when seen.
interface mem_arbiter_if #(
  parameter int NREQ      = 2,
  parameter int BITS_ADDR = 14,
  parameter int BITS_DATA = 8
);

  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           we;
  logic [NREQ*BITS_ADDR-1:0] addr;
  logic [NREQ*BITS_DATA-1:0] wdata;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           rvalid;
  logic [BITS_DATA-1:0]      rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index with highest priority this cycle
//   gnt    : one-hot winner (all zero when no request)
//   winner : binary index of the winner (0 when no request)
//   any    : at least one request present
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  // Walk ptr, ptr+1, ... (mod NREQ); the first requester seen wins.
  always_comb begin
    int idx;
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM (registered read, MEM_LAT clocks of
// read latency, write committed on the clock edge) between NREQ requesters.
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : requester bus, see mem_arbiter_if
//   mem_addr_rd       : registered RAM read address
//   mem_q             : RAM read data, forwarded unregistered as bus.rdata
//   mem_addr_wr/
//   mem_data_wr/
//   mem_wren          : registered RAM write port
// One access is granted per clock. A tag pipeline of depth MEM_LAT+1 follows
// each access so the read result is steered back to the requester that issued
// it; writes and idle cycles push invalid tags.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BITS_ADDR = DEF_BITS_ADDR,
  parameter int BITS_DATA = DEF_BITS_DATA,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_arbiter_if.slave         bus,
  output logic [BITS_ADDR-1:0] mem_addr_rd,
  input  logic [BITS_DATA-1:0] mem_q,
  output logic [BITS_ADDR-1:0] mem_addr_wr,
  output logic [BITS_DATA-1:0] mem_data_wr,
  output logic                 mem_wren
);

  localparam int IDW = clog2(NREQ);

  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [BITS_ADDR-1:0] mem_addr_rd_q, mem_addr_rd_d;
  logic [BITS_ADDR-1:0] mem_addr_wr_q, mem_addr_wr_d;
  logic [BITS_DATA-1:0] mem_data_wr_q, mem_data_wr_d;
  logic                 mem_wren_q, mem_wren_d;
  tag_t                 tag_q [MEM_LAT+1];
  tag_t                 tag_d [MEM_LAT+1];

  logic [NREQ-1:0]      pick_gnt;
  logic [IDW-1:0]       winner;
  logic                 any_req;
  logic                 grant;
  logic                 win_we;
  logic [BITS_ADDR-1:0] win_addr;
  logic [BITS_DATA-1:0] win_wdata;
  tag_t                 tag_in;
  tag_t                 tag_tail;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .winner (winner),
    .any    (any_req)
  );

  // Reset wins over a same-cycle grant: nothing is accepted while rst_n=0.
  assign grant   = rst_n & any_req;
  assign bus.gnt = rst_n ? pick_gnt : '0;

  assign win_we    = bus.we[winner];
  assign win_addr  = bus.addr[int'(winner)*BITS_ADDR +: BITS_ADDR];
  assign win_wdata = bus.wdata[int'(winner)*BITS_DATA +: BITS_DATA];

  always_comb begin
    ptr_d         = ptr_q;
    mem_addr_rd_d = mem_addr_rd_q;
    mem_addr_wr_d = mem_addr_wr_q;
    mem_data_wr_d = mem_data_wr_q;
    mem_wren_d    = 1'b0;
    tag_in        = '0;
    if (grant) begin
      if (int'(winner) == NREQ - 1) ptr_d = '0;
      else                          ptr_d = winner + IDW'(1);
      if (win_we) begin
        mem_addr_wr_d = win_addr;
        mem_data_wr_d = win_wdata;
        mem_wren_d    = 1'b1;
      end else begin
        mem_addr_rd_d = win_addr;
        tag_in.valid  = 1'b1;
        tag_in.id     = ID_W'(winner);
      end
    end
  end

  // Stage k of the tag pipe describes the access granted k+1 cycles ago, so
  // the tail (stage MEM_LAT) lines up with the cycle mem_q carries its data.
  always_comb begin
    tag_d[0] = tag_in;
    for (int k = 1; k <= MEM_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      mem_addr_rd_q <= '0;
      mem_addr_wr_q <= '0;
      mem_data_wr_q <= '0;
      mem_wren_q    <= 1'b0;
      for (int k = 0; k <= MEM_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      mem_addr_rd_q <= mem_addr_rd_d;
      mem_addr_wr_q <= mem_addr_wr_d;
      mem_data_wr_q <= mem_data_wr_d;
      mem_wren_q    <= mem_wren_d;
      for (int k = 0; k <= MEM_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign tag_tail = tag_q[MEM_LAT];

  always_comb begin
    bus.rvalid = '0;
    for (int k = 0; k < NREQ; k++) begin
      bus.rvalid[k] = tag_tail.valid && (tag_tail.id == ID_W'(k));
    end
  end

  assign bus.rdata   = mem_q;
  assign mem_addr_rd = mem_addr_rd_q;
  assign mem_addr_wr = mem_addr_wr_q;
  assign mem_data_wr = mem_data_wr_q;
  assign mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int BA = 14;
  localparam int BD = 8;
  localparam int EW = 27; // {cycle[15:0], id[2:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with 2 requesters + RAM model ----------------
  mem_arbiter_if #(.NREQ(2), .BITS_ADDR(BA), .BITS_DATA(BD)) bus ();
  logic [BA-1:0] mem_addr_rd, mem_addr_wr;
  logic [BD-1:0] mem_data_wr, mem_q;
  logic          mem_wren;

  mem_arbiter #(.NREQ(2), .BITS_ADDR(BA), .BITS_DATA(BD), .MEM_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_addr_rd (mem_addr_rd),
    .mem_q       (mem_q),
    .mem_addr_wr (mem_addr_wr),
    .mem_data_wr (mem_data_wr),
    .mem_wren    (mem_wren)
  );

  logic [BD-1:0] ram     [0:(1<<BA)-1];
  logic [BD-1:0] ref_mem [0:(1<<BA)-1];
  logic [BD-1:0] p0, p1;

  // RAM: read address sampled at the edge, data three edges later.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr_wr] <= mem_data_wr;
    p0    <= ram[mem_addr_rd];
    p1    <= p0;
    mem_q <= p1;
  end

  // ---------------- DUT with 4 requesters (arbitration only) ----------------
  mem_arbiter_if #(.NREQ(4), .BITS_ADDR(BA), .BITS_DATA(BD)) bus4 ();
  logic [BA-1:0] m4_addr_rd, m4_addr_wr;
  logic [BD-1:0] m4_data_wr;
  logic [BD-1:0] m4_q = '0;
  logic          m4_wren;

  mem_arbiter #(.NREQ(4), .BITS_ADDR(BA), .BITS_DATA(BD), .MEM_LAT(3)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus4),
    .mem_addr_rd (m4_addr_rd),
    .mem_q       (m4_q),
    .mem_addr_wr (m4_addr_wr),
    .mem_data_wr (m4_data_wr),
    .mem_wren    (m4_wren)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input int id, input logic [BA-1:0] a);
    exp_q.push_back({16'(cyc + 4), 3'(id), ref_mem[a]});
  endtask

  // Every rvalid must match the head of the queue, in the cycle recorded
  // there; an expected return that does not show up is caught too.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if ((|bus.rvalid === 1'b1) ||
        (exp_q.size() != 0 && int'(exp_q[0][26:11]) == cyc)) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_id", 32'(bus.rvalid), 32'd1 << e[10:8]);
        chk("rdata", 32'(bus.rdata), 32'(e[7:0]));
        chk("rvalid_cycle", 32'(cyc), 32'(e[26:11]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [BA-1:0] a, input logic [BD-1:0] d);
    bus.req[i]            = r;
    bus.we[i]             = w;
    bus.addr[i*BA +: BA]  = a;
    bus.wdata[i*BD +: BD] = d;
  endtask

  // ---------------- directed sequence ----------------
  logic [BA-1:0] cur_addr [2];
  int w;

  initial begin
    for (int a = 0; a < (1 << BA); a++) begin
      ram[a]     = BD'(a) ^ BD'(a >> 6);
      ref_mem[a] = BD'(a) ^ BD'(a >> 6);
    end
    ram[14'h0010]     = 8'hA5;
    ref_mem[14'h0010] = 8'hA5;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus4.req = '0; bus4.we = '0; bus4.addr = '0; bus4.wdata = '0;

    // reset state, with a request pending to show gnt is blocked
    set_req(0, 1'b1, 1'b0, 14'h0123, 8'h00);
    tick();
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_addr_rd", 32'(mem_addr_rd), 32'd0);
    chk("rst_addr_wr", 32'(mem_addr_wr), 32'd0);
    chk("rst_data_wr", 32'(mem_data_wr), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    set_req(0, 1'b0, 1'b0, 14'h0, 8'h00);
    tick();
    rst_n = 1'b1;

    // single read of 0x0010 by requester 0
    tick();
    set_req(0, 1'b1, 1'b0, 14'h0010, 8'h00);
    push_rd(0, 14'h0010);
    @(negedge clk);
    chk("rd_gnt", 32'(bus.gnt), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 14'h0, 8'h00);
    @(negedge clk);
    chk("rd_addr", 32'(mem_addr_rd), 32'h0010);
    chk("rd_gnt_drop", 32'(bus.gnt), 32'd0);
    chk("rd_wren", 32'(mem_wren), 32'd0);
    repeat (6) tick();

    // write 0x3FFF<-0x5A then read it back, requester 1
    set_req(1, 1'b1, 1'b1, 14'h3FFF, 8'h5A);
    ref_mem[14'h3FFF] = 8'h5A;
    @(negedge clk);
    chk("wr_gnt", 32'(bus.gnt), 32'b10);
    tick();
    set_req(1, 1'b1, 1'b0, 14'h3FFF, 8'h00);
    push_rd(1, 14'h3FFF);
    @(negedge clk);
    chk("wr_wren", 32'(mem_wren), 32'd1);
    chk("wr_addr", 32'(mem_addr_wr), 32'h3FFF);
    chk("wr_data", 32'(mem_data_wr), 32'h5A);
    chk("wr_rd_gnt", 32'(bus.gnt), 32'b10);
    tick();
    set_req(1, 1'b0, 1'b0, 14'h0, 8'h00);
    @(negedge clk);
    chk("wr_wren_once", 32'(mem_wren), 32'd0);
    chk("wr_rd_addr", 32'(mem_addr_rd), 32'h3FFF);
    repeat (6) tick();

    // contention from reset release: grants 0,1,0,1,... returns in order
    rst_n = 1'b0;
    cur_addr[0] = 14'h0100;
    cur_addr[1] = 14'h2200;
    set_req(0, 1'b1, 1'b0, cur_addr[0], 8'h00);
    set_req(1, 1'b1, 1'b0, cur_addr[1], 8'h00);
    @(negedge clk);
    chk("cont_rst_gnt", 32'(bus.gnt), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = k % 2;
      @(negedge clk);
      chk("cont_gnt", 32'(bus.gnt), 32'd1 << w);
      push_rd(w, cur_addr[w]);
      tick();
      cur_addr[w] = cur_addr[w] + 14'(1 + $urandom_range(0, 40));
      set_req(w, 1'b1, 1'b0, cur_addr[w], 8'h00);
    end
    set_req(0, 1'b0, 1'b0, 14'h0, 8'h00);
    set_req(1, 1'b0, 1'b0, 14'h0, 8'h00);
    repeat (6) tick();

    // reset while two reads are in flight: neither returns
    set_req(0, 1'b1, 1'b0, 14'h0010, 8'h00);
    @(negedge clk);
    chk("rmf_gnt0", 32'(bus.gnt), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 14'h0, 8'h00);
    set_req(1, 1'b1, 1'b0, 14'h0020, 8'h00);
    @(negedge clk);
    chk("rmf_gnt1", 32'(bus.gnt), 32'b10);
    tick();
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 14'h0030, 8'h00);
    set_req(1, 1'b1, 1'b0, 14'h0040, 8'h00);
    @(negedge clk);
    chk("rmf_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rmf_rst_wren", 32'(mem_wren), 32'd0);
    chk("rmf_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    set_req(0, 1'b0, 1'b0, 14'h0, 8'h00);
    set_req(1, 1'b0, 1'b0, 14'h0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmf_ptr", 32'(dut.ptr_q), 32'd0);
    chk("rmf_wren_after", 32'(mem_wren), 32'd0);
    chk("rmf_rvalid", 32'(bus.rvalid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("rmf_rvalid", 32'(bus.rvalid), 32'd0);
    end
    tick();

    // idle: one grant to requester 0 leaves ptr at 1, then 10 quiet cycles
    set_req(0, 1'b1, 1'b0, 14'h0777, 8'h00);
    push_rd(0, 14'h0777);
    @(negedge clk);
    chk("idle_pre_gnt", 32'(bus.gnt), 32'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 14'h0, 8'h00);
    repeat (5) tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(bus.gnt), 32'd0);
      chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
      chk("idle_wren", 32'(mem_wren), 32'd0);
      chk("idle_ptr", 32'(dut.ptr_q), 32'd1);
      tick();
    end

    // fairness with 4 requesters all held
    bus4.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair4_gnt", 32'(bus4.gnt), 32'd1 << (k % 4));
      tick();
    end
    bus4.req = '0;

    repeat (6) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
